ctrl_seq: RTL
=============

// Module: ctrl_seq
// PURPOSE
// - Controller-sequencer for the 8-bit SAP-style CPU; consumes the 4-bit opcode driven by the instruction register on ctrl.
// - Produces every per-cycle control strobe, including the li/ei strobes the instruction register itself samples.
// - One-hot T-state ring: fetch in T1..T3, execute in T4..T6 decoded from the opcode.
// - Halt latch freezes the machine until clr.
// PARAMETERS
// - OP_W       4  opcode width; must match the instruction register ctrl width
// - T_STATES   6  ring length; fixed at 6, any other value is illegal
// - EARLY_END  0  1: jump from the last active execute state straight to T1; 0: always run T1..T6
// PORTS
// - clk       in   1         rising-edge clock
// - clr       in   1         synchronous, active-high reset
// - opcode    in   OP_W      from instruction register ctrl; valid T4..T6 (loaded at end of T3)
// - t_state   out  T_STATES  one-hot ring; bit0 = T1
// - cp        out  1         program counter increment
// - ep        out  1         program counter drives bus
// - lm        out  1         memory address register load
// - ce        out  1         RAM drives bus (active-high)
// - li        out  1         instruction register load
// - ei        out  1         instruction register drives bus (operand nibble)
// - la        out  1         accumulator load
// - ea        out  1         accumulator drives bus
// - su        out  1         ALU subtract select
// - eu        out  1         ALU drives bus
// - lb        out  1         B register load
// - lo        out  1         output register load
// - hlt       out  1         halted flag (sticky)
// BEHAVIOUR
// - Reset:
//   - clr=1 at a rising edge -> t_state=6'b000001, halt latch=0.
//   - Applies from any state, mid-instruction included; the half-finished instruction is abandoned.
// - Outputs:
//   - Combinational decode of the registered t_state, the halt latch and opcode; no extra latency.
//   - During clr all strobes follow the T1 decode on the next cycle.
// - Ring: advances one position per clk; T6 -> T1 wrap.
// - Fetch, opcode ignored:
//   - T1: ep, lm
//   - T2: cp
//   - T3: ce, li
// - Execute, opcodes live in the shared package:
//   - LDA=4'h0: T4 ei,lm; T5 ce,la; T6 none
//   - ADD=4'h1: T4 ei,lm; T5 ce,lb; T6 eu,la
//   - SUB=4'h2: T4 ei,lm; T5 ce,lb; T6 su,eu,la (su held with eu)
//   - OUT=4'hE: T4 ea,lo; T5 none; T6 none
//   - HLT=4'hF: at the T4 edge set halt latch; ring then holds at T4
//   - any other opcode: NOP, no strobes T4..T6
// - Halted:
//   - hlt=1.
//   - All other strobes are 0, including during the HLT T4 cycle itself.
//   - t_state frozen.
//   - Only clr exits.
// - EARLY_END=1: last active state -> T1 on the next edge.
//   - LDA after T5; OUT and NOP after T4; ADD/SUB run to T6.
//   - EARLY_END=0: every instruction takes exactly 6 cycles.
// - Bus exclusivity invariant: at most one of ep, ce, ei, ea, eu is 1 in any cycle, in all states.
// - Opcode changing during T1..T3 has no effect on outputs.
// STRUCTURE
// - Shared package cpu_pkg:
//   - opcode localparams OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT
//   - T_STATES and OP_W constants
//   - control-word bit index constants
// - One sub-module ring_counter:
//   - one-hot shifter with sync clr, hold and load-T1 inputs
// - Decode stays inline in ctrl_seq as a case on (t_state, opcode).
// TESTING
// 1. clr=1 one cycle, opcode=4'h0 -> t_state=000001, ep=lm=1, all else 0, hlt=0.
// 2. LDA (4'h0), EARLY_END=0 -> six cycles:
//    {ep,lm}, {cp}, {ce,li}, {ei,lm}, {ce,la}, {}; then t_state=000001.
// 3. SUB (4'h2) -> T6 shows su=eu=la=1, lb=0.
// 4. ADD (4'h1) -> T6 shows su=0, eu=la=1.
// 5. OUT (4'hE), EARLY_END=1 -> {ea,lo} at T4, then T1 on the next cycle (4-cycle instruction).
// 6. HLT (4'hF) at T4:
//    - hlt=1, all strobes 0, t_state=001000 held 10 cycles;
//    - clr=1 -> T1, hlt=0.
// 7. clr asserted during T5 of ADD -> next cycle t_state=000001, lb not asserted.
// - Every test: check the bus-exclusivity invariant each cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ring states and control-word bit positions shared by the SAP-style CPU blocks.
package cpu_pkg;
    localparam int OP_W = 4;
    localparam int T_STATES = 6;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam int CW_W = 12;
    localparam int CW_CP = 0;
    localparam int CW_EP = 1;
    localparam int CW_LM = 2;
    localparam int CW_CE = 3;
    localparam int CW_LI = 4;
    localparam int CW_EI = 5;
    localparam int CW_LA = 6;
    localparam int CW_EA = 7;
    localparam int CW_SU = 8;
    localparam int CW_EU = 9;
    localparam int CW_LB = 10;
    localparam int CW_LO = 11;
endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T-state shifter with sync clear, hold and early return to T1.
module ring_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         hold,
    input  logic         load_t1,
    output logic [N-1:0] t_state
);
    always_ff @(posedge clk) begin
        if (clr) t_state <= N'(1);
        else if (hold) t_state <= t_state;
        else if (load_t1) t_state <= N'(1);
        else t_state <= {t_state[N-2:0], t_state[N-1]};
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: controller-sequencer for the SAP-style CPU; fetch in T1..T3, opcode-decoded execute in T4..T6.
module ctrl_seq
    import cpu_pkg::*;
#(
    parameter int OP_W = cpu_pkg::OP_W,
    parameter int T_STATES = cpu_pkg::T_STATES,
    parameter bit EARLY_END = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OP_W-1:0]     opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                cp,
    output logic                ep,
    output logic                lm,
    output logic                ce,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                lb,
    output logic                lo,
    output logic                hlt
);
    logic halt_q;
    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic last;
    logic [CW_W-1:0] cw;

    assign is_lda = opcode == OP_W'(OP_LDA);
    assign is_add = opcode == OP_W'(OP_ADD);
    assign is_sub = opcode == OP_W'(OP_SUB);
    assign is_out = opcode == OP_W'(OP_OUT);
    assign is_hlt = opcode == OP_W'(OP_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

    // hlt rises during the HLT T4 cycle itself so the ring never leaves T4
    assign hlt = halt_q || (t_state == T4 && is_hlt);
    assign last = EARLY_END && ((t_state == T5 && is_lda) || (t_state == T4 && (is_out || is_nop)));

    always_ff @(posedge clk) begin
        if (clr) halt_q <= 1'b0;
        else if (hlt) halt_q <= 1'b1;
    end

    ring_counter #(.N(T_STATES)) u_ring (
        .clk    (clk),
        .clr    (clr),
        .hold   (hlt),
        .load_t1(last),
        .t_state(t_state)
    );

    always_comb begin
        cw = '0;
        case (t_state)
            T1: begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            T2: cw[CW_CP] = 1'b1;
            T3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            T4: begin
                cw[CW_EI] = is_lda || is_add || is_sub;
                cw[CW_LM] = is_lda || is_add || is_sub;
                cw[CW_EA] = is_out;
                cw[CW_LO] = is_out;
            end
            T5: begin
                cw[CW_CE] = is_lda || is_add || is_sub;
                cw[CW_LA] = is_lda;
                cw[CW_LB] = is_add || is_sub;
            end
            T6: begin
                cw[CW_EU] = is_add || is_sub;
                cw[CW_LA] = is_add || is_sub;
                cw[CW_SU] = is_sub;
            end
            default: cw = '0;
        endcase
        if (hlt) cw = '0;
    end

    assign cp = cw[CW_CP];
    assign ep = cw[CW_EP];
    assign lm = cw[CW_LM];
    assign ce = cw[CW_CE];
    assign li = cw[CW_LI];
    assign ei = cw[CW_EI];
    assign la = cw[CW_LA];
    assign ea = cw[CW_EA];
    assign su = cw[CW_SU];
    assign eu = cw[CW_EU];
    assign lb = cw[CW_LB];
    assign lo = cw[CW_LO];
endmodule
